botoes_condicionador: RTL and testbench

Input conditioner for the seven game buttons: double-flop synchronises each raw pin, debounces it with a per-button stability counter and optionally enforces single-press (one-hot) encoding. Sits directly upstream of the S1 datapath. Its `botoes` output drives the datapath's `botoes` bus, so the jogada register, edge detector and LED mux only ever see clean, clock-aligned levels.

---
 rtl/botoes_condicionador_pkg.sv | 18 +
 rtl/botoes_condicionador_debounce_bit.sv | 65 ++++++
 rtl/botoes_condicionador.sv | 57 +++++
 tb/tb_botoes_condicionador.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/botoes_condicionador_pkg.sv
// Shared definitions for the S1 button conditioner: button count, default
// debounce length, counter-width helper and the button bus type.
package S1_pkg;

  localparam int unsigned N_BOTOES                = 7;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 20;

  typedef logic [N_BOTOES-1:0] botoes_t;

  // Width of a counter that must reach cycles-1; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    if (cycles < 2) begin
      return 1;
    end
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/botoes_condicionador_debounce_bit.sv
// debounce_bit: two-flop synchroniser plus stability counter for one button.
// A changed synchronised level must be seen on DEBOUNCE_CYCLES consecutive
// edges before it replaces the stable level; any return to the stable level
// restarts the count. zera clears everything synchronously, reset
// asynchronously.
module debounce_bit
  import S1_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic raw,
  output logic estavel
);

  localparam int unsigned    CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          est_q, est_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next state: synchroniser shift, then compare-and-count against est.
  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    est_d = est_q;
    cnt_d = '0;
    if (zera) begin
      s1_d  = 1'b0;
      s2_d  = 1'b0;
      est_d = 1'b0;
      cnt_d = '0;
    end else if (s2_q == est_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      est_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      est_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      est_q <= est_d;
      cnt_q <= cnt_d;
    end
  end

  assign estavel = est_q;

endmodule

// File: rtl/botoes_condicionador.sv
// botoes_condicionador: conditions the raw game buttons for the S1 datapath.
// One debounce_bit per button; the top adds the multi-press detector and the
// optional one-hot filter.
// Build option: define BOTOES_ONEHOT_EN to force botoes to 0 while more than
// one debounced button is high. Without it botoes mirrors the debounced levels.
module botoes_condicionador #(
  parameter int unsigned N_BOTOES        = S1_pkg::N_BOTOES,
  parameter int unsigned DEBOUNCE_CYCLES = S1_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                zera,
  input  logic [N_BOTOES-1:0] botoes_raw,
  output logic [N_BOTOES-1:0] botoes,
  output logic                multiplo,
  output logic [N_BOTOES-1:0] db_estavel
);

  import S1_pkg::*;

  localparam int unsigned PW = $clog2(N_BOTOES + 1);

  logic [N_BOTOES-1:0] est;
  logic [PW-1:0]       pop;

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clock  (clock),
      .reset  (reset),
      .zera   (zera),
      .raw    (botoes_raw[i]),
      .estavel(est[i])
    );
  end

  // Popcount of the registered stable levels; only registers feed it.
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N_BOTOES; i++) begin
      pop = pop + PW'(est[i]);
    end
  end

  // Multi-press flag and output selection.
  always_comb begin
    multiplo   = (pop > PW'(1));
    db_estavel = est;
`ifdef BOTOES_ONEHOT_EN
    botoes     = multiplo ? '0 : est;
`else
    botoes     = est;
`endif
  end

endmodule

// File: tb/tb_botoes_condicionador.sv
// Directed self-checking bench for botoes_condicionador with DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge, so the next rising edge is
// the first sampling edge; a held level appears after the 6th such edge.
module tb_botoes_condicionador;

  localparam int unsigned DC = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       zera  = 1'b0;
  logic [6:0] botoes_raw = '0;
  logic [6:0] botoes;
  logic       multiplo;
  logic [6:0] db_estavel;

  int n_checks = 0;
  int n_errors = 0;

  botoes_condicionador #(
    .N_BOTOES       (7),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .zera      (zera),
    .botoes_raw(botoes_raw),
    .botoes    (botoes),
    .multiplo  (multiplo),
    .db_estavel(db_estavel)
  );

  always #5 clock = ~clock;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Expected outputs derived from the expected debounced level.
  task automatic chk(input string tag, input logic [6:0] exp_est);
    logic [6:0] exp_b;
    logic       exp_m;
    exp_m = ($countones(exp_est) > 1);
`ifdef BOTOES_ONEHOT_EN
    exp_b = exp_m ? 7'b0 : exp_est;
`else
    exp_b = exp_est;
`endif
    n_checks++;
    assert (db_estavel === exp_est) else begin
      n_errors++;
      $error("FAIL %s db_estavel: observed %b expected %b", tag, db_estavel, exp_est);
    end
    n_checks++;
    assert (botoes === exp_b) else begin
      n_errors++;
      $error("FAIL %s botoes: observed %b expected %b", tag, botoes, exp_b);
    end
    n_checks++;
    assert (multiplo === exp_m) else begin
      n_errors++;
      $error("FAIL %s multiplo: observed %b expected %b", tag, multiplo, exp_m);
    end
  endtask

  logic [9:0] bounce_seq;

  initial begin
    // Power-on reset
    #1;
    chk("reset_init", 7'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(2);
    chk("idle", 7'b0);

    // Clean press and release
    botoes_raw = 7'b0000001;
    step(5);
    chk("press_edge5", 7'b0);
    step(1);
    chk("press_edge6", 7'b0000001);
    step(4);
    chk("press_held", 7'b0000001);
    botoes_raw = 7'b0;
    step(5);
    chk("release_edge5", 7'b0000001);
    step(1);
    chk("release_edge6", 7'b0);

    // Bounce on bit 3: 1,0,1,1,0,1,1,1,1,1 (one value per sampling edge)
    bounce_seq = 10'b1111101101;
    for (int i = 0; i < 10; i++) begin
      botoes_raw = {3'b0, bounce_seq[i], 3'b0};
      step(1);
      chk($sformatf("bounce_%0d", i), 7'b0);
    end
    step(1);
    chk("bounce_accept", 7'b0001000);
    botoes_raw = 7'b0;
    step(5);
    chk("bounce_rel5", 7'b0001000);
    step(1);
    chk("bounce_rel6", 7'b0);

    // Asynchronous reset while a button is accepted and held
    botoes_raw = 7'b0000100;
    step(6);
    chk("pre_reset", 7'b0000100);
    #2;
    reset = 1'b1;
    #1;
    chk("reset_async", 7'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(5);
    chk("after_reset5", 7'b0);
    step(1);
    chk("after_reset6", 7'b0000100);

    // Asynchronous reset pulse mid-count: no partial count survives
    botoes_raw = 7'b0;
    step(6);
    chk("drop_bit2", 7'b0);
    botoes_raw = 7'b0000100;
    step(3);
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step(5);
    chk("midcount_reset5", 7'b0);
    step(1);
    chk("midcount_reset6", 7'b0000100);

    // zera while bit 2 is held and stable
    zera = 1'b1;
    step(1);
    zera = 1'b0;
    chk("zera_clear", 7'b0);
    step(5);
    chk("zera_req5", 7'b0);
    step(1);
    chk("zera_req6", 7'b0000100);

    // zera held over several edges overrides counting
    botoes_raw = 7'b0;
    zera = 1'b1;
    step(8);
    chk("zera_hold", 7'b0);
    zera = 1'b0;
    step(2);
    chk("zera_hold_rel", 7'b0);

    // Short glitch on bit 5 (DC-1 sampling edges) is rejected
    botoes_raw = 7'b0100000;
    step(3);
    botoes_raw = 7'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk($sformatf("glitch_%0d", i), 7'b0);
    end

    // Simultaneous press of bits 0 and 6
    botoes_raw = 7'b1000001;
    step(5);
    chk("multi_edge5", 7'b0);
    step(1);
    chk("multi_edge6", 7'b1000001);
    botoes_raw = 7'b0;
    step(6);
    chk("multi_release", 7'b0);

    // Staggered press: bit 0 first, bit 6 two edges later
    botoes_raw = 7'b0000001;
    step(2);
    botoes_raw = 7'b1000001;
    step(3);
    chk("stagger_e5", 7'b0);
    step(1);
    chk("stagger_e6", 7'b0000001);
    step(1);
    chk("stagger_e7", 7'b0000001);
    step(1);
    chk("stagger_e8", 7'b1000001);
    botoes_raw = 7'b0;
    step(6);
    chk("stagger_release", 7'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
